// File: rtl/seq_shift_mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package seq_shift_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N     = 8;
    localparam int CNT_W_DEFAULT = $clog2(DEFAULT_N);

    // Step counter width for operand width n; it must hold n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_shift_mul_shift.sv
// One-bit logical left shift with zero fill, used to advance the multiplicand.
module nbit_shift_left #(
    parameter int n = 16
) (
    input  logic [n-1:0] din,
    output logic [n-1:0] dout
);

    assign dout = {din[n-2:0], 1'b0};

endmodule

// File: rtl/seq_shift_multiplier.sv
// Unsigned n x n sequential shift-and-add multiplier, one multiplier bit per clock.
// Optional macro SEQ_SHIFT_MUL_EARLY_EXIT_EN ends the run once the remaining multiplier bits are zero.
module seq_shift_multiplier
    import seq_shift_mul_pkg::*;
#(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*n-1:0] product
);

    localparam int CW = cnt_w(n);

    state_t          state, state_nxt;
    logic [2*n-1:0]  acc, acc_sum;
    logic [2*n-1:0]  mcand, mcand_shl;
    logic [n-1:0]    mplier, mplier_shr;
    logic [CW-1:0]   count;
    logic            last_edge;

    nbit_shift_left #(.n(2*n)) u_mcand_shl (
        .din  (mcand),
        .dout (mcand_shl)
    );

    // Sum wraps at 2n bits; the true product always fits.
    assign acc_sum    = acc + (mplier[0] ? mcand : '0);
    assign mplier_shr = mplier >> 1;

`ifdef SEQ_SHIFT_MUL_EARLY_EXIT_EN
    assign last_edge = (count == CW'(n-1)) || (mplier_shr == '0);
`else
    assign last_edge = (count == CW'(n-1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_edge) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= {{n{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand_shl;
                    mplier <= mplier_shr;
                    count  <= count + CW'(1);
                    if (last_edge) product <= acc_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_multiplier.sv
// Randomized self-checking bench for seq_shift_multiplier against an arithmetic reference model.
module tb_seq_shift_multiplier;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int n_cmp = 0;
    int n_err = 0;

    seq_shift_multiplier #(.n(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    // Reference model: product is plain a*b; run length depends on build.
    function automatic logic [2*N-1:0] ref_prod(input int unsigned x, input int unsigned y);
        return (2*N)'(x * y);
    endfunction

    function automatic int ref_lat(input int unsigned y);
`ifdef SEQ_SHIFT_MUL_EARLY_EXIT_EN
        int msb = 0;
        for (int i = 0; i < N; i++) if (y[i]) msb = i;
        return msb + 1;
`else
        return N;
`endif
    endfunction

    // Drive start for one rising edge; returns at the negedge after the load edge.
    task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y);
        @(negedge clk);
        start = 1'b1; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy samples until done, bounded; no comparisons here.
    task automatic wait_done(output int busyc, output bit ok);
        busyc = 0;
        ok    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) begin ok = 1'b1; return; end
            if (busy === 1'b1) busyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, product} !== {1'b0, 1'b0, 16'h0}) begin
            n_err++;
            $display("FAIL reset_state busy=%b done=%b product=%0d required 0/0/0", busy, done, product);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int          xs [3] = '{13, 255, 0};
        int          ys [3] = '{11, 255, 200};
        int          busyc;
        bit          ok;
        logic [15:0] held;
        for (int k = 0; k < 3; k++) begin
            start_op(N'(xs[k]), N'(ys[k]));
            wait_done(busyc, ok);
            n_cmp++;
            if (!ok || product !== ref_prod(xs[k], ys[k])) begin
                n_err++;
                $display("FAIL directed_prod %0d*%0d got %0d (done=%b) required %0d", xs[k], ys[k], product, ok, ref_prod(xs[k], ys[k]));
            end
            n_cmp++;
            if (busyc !== ref_lat(ys[k])) begin
                n_err++;
                $display("FAIL directed_lat %0d*%0d busy cycles %0d required %0d", xs[k], ys[k], busyc, ref_lat(ys[k]));
            end
            held = product;
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL done_width done=%b busy=%b required 0/0", done, busy);
            end
            repeat (3) @(negedge clk);
            n_cmp++;
            if (product !== held) begin
                n_err++;
                $display("FAIL product_hold got %0d required %0d", product, held);
            end
        end
    endtask

    task automatic test_ignore_start();
        int busyc;
        bit ok;
        int extra = 0;
        start_op(8'd13, 8'd11);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'd1; b = 8'd1;
        @(negedge clk);
        start = 1'b0; a = 8'd77; b = 8'd99;
        wait_done(busyc, ok);
        n_cmp++;
        if (!ok || product !== 16'd143) begin
            n_err++;
            $display("FAIL ignore_start_prod got %0d (done=%b) required 143", product, ok);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL ignore_start_extra got %0d busy/done cycles required 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int busyc;
        bit ok;
        int seen = 0;
        start_op(8'd13, 8'd11);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, product} !== {1'b0, 1'b0, 16'h0}) begin
            n_err++;
            $display("FAIL async_reset busy=%b done=%b product=%0d required 0/0/0", busy, done, product);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL reset_no_done got %0d active cycles required 0", seen);
        end
        start_op(8'd2, 8'd3);
        wait_done(busyc, ok);
        n_cmp++;
        if (!ok || product !== 16'd6 || busyc !== ref_lat(3)) begin
            n_err++;
            $display("FAIL post_reset_op got %0d lat %0d required 6 lat %0d", product, busyc, ref_lat(3));
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] x1, y1, x2, y2;
        int           busyc, gap;
        bit           ok;
        x1 = N'($urandom_range(0, 255)); y1 = N'($urandom_range(128, 255));
        x2 = N'($urandom_range(0, 255)); y2 = N'($urandom_range(0, 255));
        @(negedge clk);
        start = 1'b1; a = x1; b = y1;
        @(negedge clk);
        a = x2; b = y2;
        wait_done(busyc, ok);
        n_cmp++;
        if (!ok || product !== ref_prod(x1, y1)) begin
            n_err++;
            $display("FAIL b2b_first got %0d required %0d", product, ref_prod(x1, y1));
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_turnaround done=%b busy=%b required 0/1", done, busy);
        end
        wait_done(busyc, ok);
        gap = busyc + 1;
        n_cmp++;
        if (!ok || product !== ref_prod(x2, y2) || gap !== ref_lat(y2) + 1) begin
            n_err++;
            $display("FAIL b2b_second got %0d gap %0d required %0d gap %0d", product, gap, ref_prod(x2, y2), ref_lat(y2) + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [N-1:0] x, y;
        int           busyc;
        bit           ok;
        for (int k = 0; k < 20; k++) begin
            x = N'($urandom);
            y = (k < 4) ? N'(1 << k) : N'($urandom);
            start_op(x, y);
            wait_done(busyc, ok);
            n_cmp++;
            if (!ok || product !== ref_prod(x, y) || busyc !== ref_lat(y)) begin
                n_err++;
                $display("FAIL random %0d*%0d got %0d lat %0d required %0d lat %0d", x, y, product, busyc, ref_prod(x, y), ref_lat(y));
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
